// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops and a WIDTH-cycle shift-add multiply.
// Results and flags are registered and held until the next operation completes.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               cout,
    output logic               zero,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               cout_q, cout_d, zero_q, zero_d, busy_q, busy_d, done_q, done_d;

    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   val;
    logic               val_c;

    // The extra top bit of diff_w is the borrow, i.e. a_q < b_q.
    always_comb begin
        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        diff_w = {1'b0, a_q} - {1'b0, b_q};
        val    = '0;
        val_c  = 1'b0;
        case (op_q)
            3'b000:  begin val = sum_w[WIDTH-1:0];  val_c = sum_w[WIDTH];  end
            3'b001:  begin val = diff_w[WIDTH-1:0]; val_c = diff_w[WIDTH]; end
            3'b010:  val = a_q & b_q;
            3'b011:  val = a_q | b_q;
            3'b100:  val = a_q ^ b_q;
            3'b101:  val = ~a_q;
            default: val = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    op_d   = op;
                    busy_d = 1'b1;
                    if (op == 3'b110) begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                result_d = {{WIDTH{1'b0}}, val};
                cout_d   = val_c;
                zero_d   = (val == '0);
                done_d   = 1'b1;
                state_d  = DONE;
            end
            MUL: begin
                // WIDTH accumulate steps, then one cycle to publish the product.
                if (cnt_q == CW'(WIDTH)) begin
                    result_d = acc_q;
                    cout_d   = 1'b0;
                    zero_d   = (acc_q == '0);
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): expected {result,cout,zero} words queue up at
// stimulus time and are popped when done is observed.
module tb_seq_alu;
    localparam int W  = 8;
    localparam int EW = 2*W + 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     op = '0;
    logic [W-1:0]   a = '0, b = '0;
    logic [2*W-1:0] result;
    logic           cout, zero, busy, done;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int cyc, pulses;
    logic [EW-1:0] e;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .result(result), .cout(cout), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] r;
        logic [W-1:0]   nx;
        logic           c;
        int             s;
        r = '0;
        c = 1'b0;
        nx = ~x;
        case (o)
            3'd0: begin s = int'(x) + int'(y); r = {8'h00, s[7:0]}; c = (s > 255); end
            3'd1: begin s = int'(x) - int'(y); r = {8'h00, s[7:0]}; c = (x < y); end
            3'd2: r = {8'h00, x & y};
            3'd3: r = {8'h00, x | y};
            3'd4: r = {8'h00, x ^ y};
            3'd5: r = {8'h00, nx};
            3'd6: r = 16'(x) * 16'(y);
            default: r = '0;
        endcase
        return {r, c, (r == '0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int c, bc;
        logic [EW-1:0] ex;
        exp_q.push_back(model(o, x, y));
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        bc = int'(busy);
        while (!done && c < 60) begin
            @(posedge clk); #1;
            c++;
            bc += int'(busy);
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("latency", 32'(c), (o == 3'b110) ? 32'(W + 2) : 32'd2);
        chk("busy_cycles", 32'(bc), 32'(c));
        ex = exp_q.pop_front();
        chk("result", 32'({result, cout, zero}), 32'(ex));
        @(posedge clk); #1;
        chk("idle_after", 32'({busy, done}), 32'd0);
        chk("hold", 32'({result, cout, zero}), 32'(ex));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'({cout, zero, busy, done}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'b000, 8'd200, 8'd100);
        chk("add_200_100", 32'({result, cout, zero}), 32'({16'h002C, 1'b1, 1'b0}));
        run_op(3'b001, 8'd5, 8'd7);
        chk("sub_5_7", 32'({result, cout}), 32'({16'h00FE, 1'b1}));
        run_op(3'b001, 8'd9, 8'd9);
        chk("sub_9_9", 32'({result, cout, zero}), 32'({16'h0000, 1'b0, 1'b1}));
        run_op(3'b110, 8'd255, 8'd255);
        chk("mul_255_255", 32'({result, cout}), 32'({16'hFE01, 1'b0}));
        run_op(3'b010, 8'hF0, 8'h3C);
        run_op(3'b011, 8'hF0, 8'h3C);
        run_op(3'b100, 8'hF0, 8'h3C);
        run_op(3'b101, 8'hFF, 8'h00);
        chk("not_ff", 32'({result, zero}), 32'({16'h0000, 1'b1}));
        run_op(3'b111, 8'hFF, 8'h12);
        chk("rsvd", 32'({result, cout, zero}), 32'({16'h0000, 1'b0, 1'b1}));
        run_op(3'b101, 8'h0F, 8'h00);
        for (int i = 0; i < 6; i++)
            run_op(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        // start held high; operands change mid-multiply
        exp_q.push_back(model(3'b110, 8'd13, 8'd11));
        op = 3'b110; a = 8'd13; b = 8'd11; start = 1'b1;
        @(posedge clk); #1;
        a = 8'd200; b = 8'd3;
        exp_q.push_back(model(3'b110, 8'd200, 8'd3));
        cyc = 1;
        pulses = 0;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("held_latency", 32'(cyc), 32'(W + 2));
        e = exp_q.pop_front();
        chk("held_result1", 32'({result, cout, zero}), 32'(e));
        @(posedge clk); #1;
        chk("held_idle", 32'({busy, done}), 32'd0);
        @(posedge clk); #1;
        chk("held_restart", 32'(busy), 32'd1);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("held_latency2", 32'(cyc), 32'(W + 2));
        e = exp_q.pop_front();
        chk("held_result2", 32'({result, cout, zero}), 32'(e));
        @(posedge clk); #1;
        chk("held_single_pulse", 32'(done), 32'd0);
        @(posedge clk); #1;

        // reset in the middle of a multiply
        run_op(3'b110, 8'd17, 8'd19);
        op = 3'b110; a = 8'd99; b = 8'd77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        chk("rst_result", 32'({result, cout, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            pulses += int'(done);
        end
        chk("rst_no_done", 32'(pulses), 32'd0);
        run_op(3'b110, 8'd3, 8'd4);
        run_op(3'b000, 8'd1, 8'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 4..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request strobe, sampled on the rising edge of clk.
REQ-005 SHALL have port op, input, 3 bits: opcode, captured together with start.
REQ-006 SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-007 SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-008 SHALL have port result, output, 2*WIDTH bits: registered result.
REQ-009 SHALL have port cout, output, 1 bit: registered carry/borrow flag.
REQ-010 SHALL have port zero, output, 1 bit: registered flag, high when result is all zeros.
REQ-011 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 SHALL use four states: IDLE, EXEC, MUL, DONE.
REQ-014 SHALL, in IDLE with start=1, capture a, b and op into internal registers and advance to MUL if op=110, otherwise to EXEC.
REQ-015 SHALL ignore start in every state other than IDLE, so inputs arriving while busy are dropped and never queued.
REQ-016 SHALL decode op as follows: 000 add, 001 sub (A-B), 010 and, 011 or, 100 xor, 101 not A, 110 multiply, 111 reserved (result 0, cout 0).
REQ-017 SHALL, in EXEC, compute the captured op in one cycle, load result/cout/zero, and advance to DONE.
REQ-018 SHALL, for every non-multiply op, zero-extend the WIDTH-bit value into result, so result[2*WIDTH-1:WIDTH]=0.
REQ-019 SHALL set cout to the carry out of bit WIDTH-1 for add, to 1 for sub when A<B (borrow), and to 0 for all other ops.
REQ-020 SHALL wrap add and sub results modulo 2^WIDTH.
REQ-021 SHALL, in MUL, run a shift-add multiply one bit of B per cycle for exactly WIDTH cycles, then load the full 2*WIDTH-bit product, set cout=0, and advance to DONE.
REQ-022 SHALL drive done=1 only in DONE, for exactly one cycle, and then return to IDLE.
REQ-023 SHALL drive busy=1 in EXEC, MUL and DONE, and busy=0 only in IDLE.
REQ-024 SHALL give a latency from the start-sampling edge to done of 2 cycles for non-multiply ops and WIDTH+2 cycles for multiply.
REQ-025 SHALL accept a new start in the IDLE cycle immediately after done (one idle cycle minimum between operations).
REQ-026 SHALL hold result, cout and zero stable from the DONE cycle until the next operation's DONE cycle loads new values.
REQ-027 SHALL compute zero from the new result value at the same edge that loads result.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE and result=0, cout=0, zero=0, busy=0, done=0 immediately, independent of clk.
REQ-029 SHALL abort any in-progress operation when rst_n is asserted, so no done pulse is produced for it.
REQ-030 SHALL clear internal operand and multiply registers on reset, so the first operation after reset carries no stale state.

Verification (WIDTH=8)
REQ-031 SHALL be verified with: add a=200, b=100 -> done 2 cycles after start, result=0x002C, cout=1, zero=0.
REQ-032 SHALL be verified with: sub a=5, b=7 -> result=0x00FE, cout=1; sub a=9, b=9 -> result=0, zero=1, cout=0.
REQ-033 SHALL be verified with: mul a=255, b=255 -> busy high for 10 cycles, done 10 cycles after start, result=0xFE01, cout=0.
REQ-034 SHALL be verified with: start held high continuously during a multiply, with a and b changed mid-operation -> the product uses the originally captured operands, exactly one done pulse per operation, and the next operation starts in the IDLE cycle after done.
REQ-035 SHALL be verified with: rst_n pulsed low 3 cycles into a multiply -> busy and done drop to 0 immediately, result=0, and no done pulse follows.
REQ-036 SHALL be verified with: op=111 and op=101 with a=0xFF -> result=0x0000 with zero=1 in both cases.
